// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit : RV32I memory-access stage, valid/ready bus master with
//                   byte-lane alignment, load extension and fault detection.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        access_fault,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_error
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_REQ   = 2'd1;
  localparam logic [1:0]  S_RESP  = 2'd2;
  localparam logic [1:0]  S_DONE  = 2'd3;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] load_data_q, load_data_d;
  logic        mis_q, mis_d, fault_q, fault_d;
  logic [15:0] cnt_q, cnt_d;
  logic        capture, req_illegal, req_mis, timeout_hit;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_fmt;

  assign capture     = (state_q == S_IDLE) && req_valid;
  // Loads allow funct3 0,1,2,4,5; stores allow only 0,1,2.
  assign req_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3[2] && (req_we || req_funct3[1]));
  assign req_mis     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign timeout_hit = (cnt_q == TO_LAST);

  always_comb begin
    rd_byte = bus_rdata[8*addr_q[1:0] +: 8];
    rd_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3_q)
      3'd0:    rd_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'd1:    rd_fmt = {{16{rd_half[15]}}, rd_half};
      3'd4:    rd_fmt = {24'd0, rd_byte};
      3'd5:    rd_fmt = {16'd0, rd_half};
      default: rd_fmt = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mis_d       = 1'b0;
    fault_d     = 1'b0;
    load_data_d = load_data_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_illegal) begin
            state_d     = S_DONE;
            fault_d     = 1'b1;
            load_data_d = 32'd0;
          end else if (req_mis) begin
            state_d     = S_DONE;
            mis_d       = 1'b1;
            load_data_d = 32'd0;
          end else begin
            state_d = S_REQ;
            cnt_d   = 16'd0;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (timeout_hit) begin
          state_d     = S_DONE;
          fault_d     = 1'b1;
          load_data_d = 32'd0;
        end else if (bus_req_ready) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + 16'd1;
        // A response arriving on the last allowed cycle still completes normally.
        if (bus_rsp_valid) begin
          state_d     = S_DONE;
          fault_d     = bus_error;
          load_data_d = (bus_error || we_q) ? 32'd0 : rd_fmt;
        end else if (timeout_hit) begin
          state_d     = S_DONE;
          fault_d     = 1'b1;
          load_data_d = 32'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      load_data_q <= 32'd0;
      mis_q       <= 1'b0;
      fault_q     <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      if (capture) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      load_data_q <= load_data_d;
      mis_q       <= mis_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    done          = (state_q == S_DONE);
    stall         = capture || (state_q == S_REQ) || (state_q == S_RESP);
    misaligned    = done && mis_q;
    access_fault  = done && fault_q;
    load_data     = load_data_q;
    bus_req_valid = (state_q == S_REQ);
    bus_addr      = {addr_q[31:2], 2'b00};
    bus_we        = we_q;
    bus_wstrb     = 4'b0000;
    bus_wdata     = wdata_q;
    if (we_q) begin
      case (funct3_q[1:0])
        2'b00: begin
          bus_wstrb = 4'b0001 << addr_q[1:0];
          bus_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          bus_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
          bus_wdata = {2{wdata_q[15:0]}};
        end
        default: bus_wstrb = 4'b1111;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit : directed self-checking bench for load_store_unit.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, misaligned, access_fault;
  logic [31:0] load_data;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rsp_valid, bus_error;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .load_data(load_data),
    .misaligned(misaligned), .access_fault(access_fault),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid),
    .bus_rdata(bus_rdata), .bus_error(bus_error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    #1;
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] waddr, input logic [31:0] rdata,
                          input logic [31:0] exp);
    bus_req_ready = 1'b1;
    start(1'b0, f3, addr, 32'h0);
    chk({tag, ".t0_stall"}, stall, 1);
    chk({tag, ".t0_brv"}, bus_req_valid, 0);
    step();
    chk({tag, ".t1_brv"}, bus_req_valid, 1);
    chk({tag, ".t1_addr"}, bus_addr, waddr);
    chk({tag, ".t1_wstrb"}, bus_wstrb, 0);
    chk({tag, ".t1_we"}, bus_we, 0);
    step();
    bus_rsp_valid = 1'b1;
    bus_rdata     = rdata;
    chk({tag, ".t2_done"}, done, 0);
    chk({tag, ".t2_stall"}, stall, 1);
    step();
    bus_rsp_valid = 1'b0;
    req_valid     = 1'b0;
    chk({tag, ".t3_done"}, done, 1);
    chk({tag, ".t3_data"}, load_data, exp);
    chk({tag, ".t3_mis"}, misaligned, 0);
    chk({tag, ".t3_fault"}, access_fault, 0);
    chk({tag, ".t3_stall"}, stall, 0);
    step();
    chk({tag, ".t4_done"}, done, 0);
    chk({tag, ".t4_hold"}, load_data, exp);
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] waddr,
                           input logic [3:0] strb, input logic [31:0] lanes);
    bus_req_ready = 1'b1;
    start(1'b1, f3, addr, wdata);
    step();
    chk({tag, ".brv"}, bus_req_valid, 1);
    chk({tag, ".we"}, bus_we, 1);
    chk({tag, ".addr"}, bus_addr, waddr);
    chk({tag, ".wstrb"}, bus_wstrb, strb);
    chk({tag, ".wdata"}, bus_wdata, lanes);
    step();
    bus_rsp_valid = 1'b1;
    step();
    bus_rsp_valid = 1'b0;
    req_valid     = 1'b0;
    chk({tag, ".done"}, done, 1);
    chk({tag, ".data"}, load_data, 0);
    chk({tag, ".fault"}, access_fault, 0);
    step();
  endtask

  task automatic run_early(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic exp_mis,
                           input logic exp_fault);
    bus_req_ready = 1'b1;
    start(we, f3, addr, 32'h5555_AAAA);
    chk({tag, ".t0_brv"}, bus_req_valid, 0);
    step();
    req_valid = 1'b0;
    chk({tag, ".t1_done"}, done, 1);
    chk({tag, ".t1_mis"}, misaligned, exp_mis);
    chk({tag, ".t1_fault"}, access_fault, exp_fault);
    chk({tag, ".t1_brv"}, bus_req_valid, 0);
    chk({tag, ".t1_data"}, load_data, 0);
    step();
    chk({tag, ".t2_done"}, done, 0);
    chk({tag, ".t2_mis"}, misaligned, 0);
    chk({tag, ".t2_fault"}, access_fault, 0);
  endtask

  initial begin
    reset_n       = 1'b0;
    req_valid     = 1'b0;
    req_we        = 1'b0;
    req_funct3    = 3'd0;
    req_addr      = 32'h0;
    req_wdata     = 32'h0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rdata     = 32'h0;
    bus_error     = 1'b0;
    step();
    step();
    chk("rst.done", done, 0);
    chk("rst.stall", stall, 0);
    chk("rst.brv", bus_req_valid, 0);
    chk("rst.data", load_data, 0);
    chk("rst.addr", bus_addr, 0);
    chk("rst.wstrb", bus_wstrb, 0);
    reset_n = 1'b1;
    step();

    run_load("lb",  3'd0, 32'h103, 32'h100, 32'h8011_2233, 32'hFFFF_FF80);
    run_load("lbu", 3'd4, 32'h101, 32'h100, 32'h8011_2233, 32'h0000_0022);
    run_load("lh",  3'd1, 32'h200, 32'h200, 32'h1234_8001, 32'hFFFF_8001);
    run_load("lhu", 3'd5, 32'h202, 32'h200, 32'hBEEF_1234, 32'h0000_BEEF);
    run_load("lw",  3'd2, 32'h204, 32'h204, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // bus error response on a load
    bus_req_ready = 1'b1;
    start(1'b0, 3'd2, 32'h200, 32'h0);
    step();
    step();
    bus_rsp_valid = 1'b1;
    bus_error     = 1'b1;
    bus_rdata     = 32'h1234_5678;
    step();
    bus_rsp_valid = 1'b0;
    bus_error     = 1'b0;
    req_valid     = 1'b0;
    chk("err.done", done, 1);
    chk("err.fault", access_fault, 1);
    chk("err.data", load_data, 0);
    step();

    run_store("sb", 3'd0, 32'h102, 32'h0000_00AB, 32'h100, 4'b0100, 32'hABAB_ABAB);
    run_store("sh", 3'd1, 32'h106, 32'hFFFF_1234, 32'h104, 4'b1100, 32'h1234_1234);

    // store with bus_req_ready held low for three cycles
    bus_req_ready = 1'b0;
    start(1'b1, 3'd2, 32'h108, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait.brv", bus_req_valid, 1);
      chk("wait.addr", bus_addr, 32'h108);
      chk("wait.wdata", bus_wdata, 32'hDEAD_BEEF);
      chk("wait.wstrb", bus_wstrb, 4'b1111);
      chk("wait.stall", stall, 1);
    end
    step();
    bus_req_ready = 1'b1;
    chk("wait.t4_brv", bus_req_valid, 1);
    step();
    bus_rsp_valid = 1'b1;
    chk("wait.t5_brv", bus_req_valid, 0);
    chk("wait.t5_done", done, 0);
    chk("wait.t5_stall", stall, 1);
    step();
    bus_rsp_valid = 1'b0;
    req_valid     = 1'b0;
    chk("wait.t6_done", done, 1);
    chk("wait.t6_data", load_data, 0);
    step();

    run_early("mis_lh", 1'b0, 3'd1, 32'h101, 1'b1, 1'b0);
    run_early("mis_sw", 1'b1, 3'd2, 32'h102, 1'b1, 1'b0);
    run_early("ill_ld3", 1'b0, 3'd3, 32'h100, 1'b0, 1'b1);
    run_early("ill_st4", 1'b1, 3'd4, 32'h100, 1'b0, 1'b1);

    // restore a non-zero load result before the timeout case
    run_load("lw2", 3'd2, 32'h300, 32'h300, 32'h0000_0077, 32'h0000_0077);

    // timeout with the bus never ready
    bus_req_ready = 1'b0;
    start(1'b0, 3'd2, 32'h300, 32'h0);
    step();
    for (int i = 1; i < 8; i++) step();
    chk("to.t8_brv", bus_req_valid, 1);
    chk("to.t8_done", done, 0);
    chk("to.t8_stall", stall, 1);
    step();
    req_valid = 1'b0;
    chk("to.t9_done", done, 1);
    chk("to.t9_fault", access_fault, 1);
    chk("to.t9_brv", bus_req_valid, 0);
    chk("to.t9_data", load_data, 0);
    step();
    bus_rsp_valid = 1'b1;
    bus_rdata     = 32'hFFFF_FFFF;
    step();
    bus_rsp_valid = 1'b0;
    chk("late.done", done, 0);
    chk("late.stall", stall, 0);
    chk("late.data", load_data, 0);
    chk("late.brv", bus_req_valid, 0);

    // load with a non-zero result so reset clearing is visible
    run_load("lw3", 3'd2, 32'h404, 32'h404, 32'h0000_0099, 32'h0000_0099);

    // asynchronous reset while waiting for the response
    bus_req_ready = 1'b1;
    start(1'b0, 3'd2, 32'h400, 32'h0);
    step();
    step();
    req_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk("arst.brv", bus_req_valid, 0);
    chk("arst.stall", stall, 0);
    chk("arst.done", done, 0);
    chk("arst.data", load_data, 0);
    reset_n = 1'b1;
    step();
    chk("arst.c1_done", done, 0);
    bus_rsp_valid = 1'b1;
    step();
    bus_rsp_valid = 1'b0;
    chk("arst.c2_done", done, 0);
    step();
    chk("arst.c3_done", done, 0);
    chk("arst.c3_stall", stall, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage between the ALU result and the data memory bus of the RV32I core. It turns a load/store request into a single valid/ready bus transaction and aligns byte lanes for SB/SH/SW. It formats load data (LB/LH/LW/LBU/LHU) with sign/zero extension and detects misaligned and faulting accesses. The core is stalled until the access completes, so data memory may be multi-cycle.

Parameters:
TIMEOUT_CYCLES, 255, cycles allowed in REQ+RESP before the access is aborted with access_fault; legal range 1..65535.

Ports:
clk  input  1  clock
reset_n  input  1  reset, asynchronous, active-low
req_valid  input  1  core requests a memory access; held stable until done
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  instruction[14:12]
req_addr  input  32  byte address (ALU result)
req_wdata  input  32  store data (rs2)
stall  output  1  freeze PC/regfile write
done  output  1  one-cycle completion pulse
load_data  output  32  formatted load result, valid when done
misaligned  output  1  qualifies done: misaligned access
access_fault  output  1  qualifies done: bus error, timeout or illegal funct3
bus_req_valid  output  1  bus request
bus_req_ready  input  1  bus accepts request
bus_addr  output  32  word-aligned address, {addr[31:2],2'b00}
bus_we  output  1  write
bus_wstrb  output  4  byte enables; 0000 for reads
bus_wdata  output  32  lane-replicated store data
bus_rsp_valid  input  1  response/ack, single cycle
bus_rdata  input  32  read data
bus_error  input  1  error, qualified by bus_rsp_valid

Behaviour:
- FSM states: IDLE, REQ, RESP, DONE. Reset: IDLE; all outputs 0; timeout counter 0; captured request registers 0.
- IDLE, req_valid=1: capture we/funct3/addr/wdata.
  - Illegal funct3 (load 3,6,7; store 3..7) -> DONE with access_fault=1.
  - Misaligned (LH/LHU/SH addr[0]!=0; LW/SW addr[1:0]!=0) -> DONE with misaligned=1.
  - Otherwise -> REQ.
  - In these cases no bus request is issued.
- REQ: bus_req_valid=1. bus_addr/bus_we/bus_wstrb/bus_wdata come from captured registers and stay stable until handshake. On bus_req_valid & bus_req_ready -> RESP.
- RESP: wait for bus_rsp_valid.
  - bus_error=1 -> DONE with access_fault=1, load_data=0.
  - Else -> DONE. For loads, register the formatted bus_rdata.
- Timeout: counter clears on IDLE->REQ and increments each cycle in REQ or RESP. When it reaches TIMEOUT_CYCLES without completing -> DONE with access_fault=1, load_data=0, bus_req_valid dropped.
- DONE: done=1 for exactly one cycle, stall=0 -> IDLE. misaligned and access_fault are valid only while done=1; 0 otherwise.
- stall = (IDLE & req_valid) | REQ | RESP.
- Minimum latency with ready=1 and response on the next cycle: accept at T0, REQ T1, RESP T2, done T3. The core advances at the edge after T3.
- Load formatting (lane = addr[1:0]):
  - LB: sign-extend byte[lane]. LBU: zero-extend byte[lane].
  - LH: sign-extend half[addr[1]]. LHU: zero-extend half[addr[1]].
  - LW: full word.
- Store lanes:
  - SB: wstrb = 0001<<lane, wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011 or 1100, wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111.
- load_data is 0 on stores and faults. It holds its value until the next done.
- bus_rsp_valid in IDLE, REQ or DONE (late/stray response) is ignored; no state change.
- Async reset mid-transaction: immediate return to IDLE; bus_req_valid drops combinationally with reset; no done pulse.

Test Plan:
- LB addr=0x103, bus_rdata=0x80112233, ready=1, rsp one cycle later -> bus_addr=0x100, wstrb=0000, done at T3, load_data=0xFFFFFF80.
- LHU addr=0x202, bus_rdata=0xBEEF1234 -> load_data=0x0000BEEF. LW addr=0x204 -> load_data = bus_rdata.
- SB addr=0x102, wdata=0x000000AB -> bus_wstrb=0100, bus_wdata=0xABABABAB, bus_we=1. SH addr=0x106, wdata=0x1234 -> wstrb=1100, wdata=0x12341234.
- LH addr=0x101 -> done at T1 with misaligned=1, bus_req_valid never asserted. Load funct3=3 -> done with access_fault=1.
- bus_req_ready low 3 cycles -> bus_addr/wdata/wstrb stable, stall=1 throughout, done one cycle after the response. bus_error=1 on response -> access_fault=1, load_data=0.
- TIMEOUT_CYCLES=8, no response -> done with access_fault=1 eight cycles after entering REQ. A late bus_rsp_valid is ignored. reset_n pulsed in RESP -> IDLE, no done.
